// File: rtl/pack8to16_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pack8to16_if : byte-in / word-out valid-ready bundle for pack8to16        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface pack8to16_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_word;
    logic        out_partial;
    logic        out_valid;
    logic        out_ready;

    // master: byte source plus word sink; slave: the packer itself
    modport master (
        output in_byte, in_valid, in_last, out_ready,
        input  in_ready, out_word, out_partial, out_valid
    );

    modport slave (
        input  in_byte, in_valid, in_last, out_ready,
        output in_ready, out_word, out_partial, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/pack8to16.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pack8to16 : pairs bytes into 16-bit words, flushing odd tails as partials |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module pack8to16 #(
    parameter int         LOW_FIRST = 1,
    parameter logic [7:0] PAD       = 8'h00,
    parameter int         CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pack8to16_if.slave            bus,
    output logic [CNT_W-1:0]      word_count
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [7:0]         r_hold;
    logic [15:0]        r_word;
    logic               r_partial;
    logic               r_valid;
    logic [CNT_W-1:0]   r_count;

    logic               w_in_ready;
    logic               w_in_hs;
    logic               w_out_hs;
    logic [15:0]        w_pair_word;
    logic [15:0]        w_part_word;

    // The output slot frees up in the same cycle the sink takes it.
    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_in_hs    = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_valid && bus.out_ready;

    generate
        if (LOW_FIRST != 0) begin : g_low_first
            assign w_pair_word = {bus.in_byte, r_hold};
            assign w_part_word = {PAD, bus.in_byte};
        end else begin : g_high_first
            assign w_pair_word = {r_hold, bus.in_byte};
            assign w_part_word = {bus.in_byte, PAD};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_hold    <= 8'h00;
            r_word    <= 16'h0000;
            r_partial <= 1'b0;
            r_valid   <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_out_hs) begin
                r_valid <= 1'b0;
                r_count <= r_count + c_cnt_one;
            end
            // A load in the same cycle overrides the valid clear above.
            if (w_in_hs) begin
                case (r_state)
                    S_EMPTY: begin
                        if (bus.in_last) begin
                            r_word    <= w_part_word;
                            r_partial <= 1'b1;
                            r_valid   <= 1'b1;
                        end else begin
                            r_hold  <= bus.in_byte;
                            r_state <= S_HALF;
                        end
                    end
                    S_HALF: begin
                        r_word    <= w_pair_word;
                        r_partial <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= S_EMPTY;
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_word    = r_word;
    assign bus.out_partial = r_partial;
    assign bus.out_valid   = r_valid;
    assign word_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pack8to16.sv
`default_nettype none
// Bench for pack8to16: one low-first/CNT_W=4 instance and one high-first/PAD=A5 instance share stimulus.
module tb_pack8to16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    pack8to16_if bus_a ();
    pack8to16_if bus_b ();

    assign bus_a.in_byte   = in_byte;
    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_byte   = in_byte;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;

    pack8to16 #(.LOW_FIRST(1), .PAD(8'h00), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .word_count(cnt_a)
    );
    pack8to16 #(.LOW_FIRST(0), .PAD(8'hA5), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .word_count(cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs for the cycle, and the outputs expected during that cycle (before its edge).
    typedef struct {
        bit          rst_n;
        bit          iv;
        bit          last;
        bit          ordy;
        logic [7:0]  b;
        bit          e_ir;
        bit          e_ov;
        bit          e_part;
        bit          chk;
        logic [15:0] e_wa;
        logic [15:0] e_wb;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [23];

    task automatic drive(input bit r, input bit v, input bit l, input bit o, input logic [7:0] b);
        rst_n     = r;
        in_valid  = v;
        in_last   = l;
        out_ready = o;
        in_byte   = b;
    endtask

    initial begin
        tbl[0]  = '{1'b1,1'b1,1'b0,1'b1,8'h34, 1'b1,1'b0,1'b0,1'b1,16'h0000,16'h0000,16'd0};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b1,8'h12, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b0,1'b1,16'h1234,16'h3412,16'd0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b1,8'hAA, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd1};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b1,8'hBB, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd1};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,8'hCC, 1'b1,1'b1,1'b0,1'b1,16'hBBAA,16'hAABB,16'd1};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b1,1'b1,16'h00CC,16'hCCA5,16'd2};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,8'h01, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd3};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,8'h02, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd3};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,8'h03, 1'b0,1'b1,1'b0,1'b1,16'h0201,16'h0102,16'd3};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b0,8'h03, 1'b0,1'b1,1'b0,1'b1,16'h0201,16'h0102,16'd3};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b1,8'h03, 1'b1,1'b1,1'b0,1'b1,16'h0201,16'h0102,16'd3};
        tbl[12] = '{1'b1,1'b1,1'b1,1'b1,8'h04, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd4};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b0,1'b1,16'h0403,16'h0304,16'd4};
        tbl[14] = '{1'b1,1'b1,1'b0,1'b1,8'h55, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd5};
        tbl[15] = '{1'b0,1'b1,1'b1,1'b1,8'h66, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd5};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b1,8'h01, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0};
        tbl[17] = '{1'b1,1'b1,1'b0,1'b1,8'h02, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd0};
        tbl[18] = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b0,1'b1,16'h0201,16'h0102,16'd0};
        tbl[19] = '{1'b1,1'b1,1'b1,1'b0,8'h07, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'd1};
        tbl[20] = '{1'b1,1'b1,1'b0,1'b0,8'h08, 1'b0,1'b1,1'b1,1'b1,16'h0007,16'h07A5,16'd1};
        tbl[21] = '{1'b0,1'b1,1'b0,1'b1,8'h08, 1'b1,1'b1,1'b1,1'b1,16'h0007,16'h07A5,16'd1};
        tbl[22] = '{1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b1,16'h0000,16'h0000,16'd0};

        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i].rst_n, tbl[i].iv, tbl[i].last, tbl[i].ordy, tbl[i].b);
            #1;
            check($sformatf("row%0d in_ready_a", i), {15'd0, bus_a.in_ready}, {15'd0, tbl[i].e_ir});
            check($sformatf("row%0d in_ready_b", i), {15'd0, bus_b.in_ready}, {15'd0, tbl[i].e_ir});
            check($sformatf("row%0d out_valid_a", i), {15'd0, bus_a.out_valid}, {15'd0, tbl[i].e_ov});
            check($sformatf("row%0d out_valid_b", i), {15'd0, bus_b.out_valid}, {15'd0, tbl[i].e_ov});
            check($sformatf("row%0d count_a", i), {12'd0, cnt_a}, {12'd0, tbl[i].e_cnt[3:0]});
            check($sformatf("row%0d count_b", i), cnt_b, tbl[i].e_cnt);
            if (tbl[i].chk) begin
                check($sformatf("row%0d word_a", i), bus_a.out_word, tbl[i].e_wa);
                check($sformatf("row%0d word_b", i), bus_b.out_word, tbl[i].e_wb);
                check($sformatf("row%0d partial_a", i), {15'd0, bus_a.out_partial}, {15'd0, tbl[i].e_part});
                check($sformatf("row%0d partial_b", i), {15'd0, bus_b.out_partial}, {15'd0, tbl[i].e_part});
            end
        end

        // Continuous stream of 17 words: CNT_W=4 counter wraps after 16.
        for (int j = 0; j < 36; j++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            @(negedge clk);
            drive(1'b1, (j < 34), 1'b0, 1'b1, 8'(j));
            #1;
            lo = 8'(j - 2);
            hi = 8'(j - 1);
            check($sformatf("stream%0d out_valid_a", j), {15'd0, bus_a.out_valid},
                  {15'd0, (j >= 2 && (j % 2) == 0)});
            if (j >= 2 && (j % 2) == 0) begin
                check($sformatf("stream%0d word_a", j), bus_a.out_word, {hi, lo});
                check($sformatf("stream%0d word_b", j), bus_b.out_word, {lo, hi});
                check($sformatf("stream%0d count_a", j), {12'd0, cnt_a}, 16'((j / 2 - 1) % 16));
                check($sformatf("stream%0d count_b", j), cnt_b, 16'(j / 2 - 1));
            end
        end
        check("wrap count_a", {12'd0, cnt_a}, 16'd1);
        check("wrap count_b", cnt_b, 16'd17);

        // Five-cycle stall with a byte waiting, then release with a last byte.
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h33);
            #1;
            check($sformatf("stall%0d in_ready_a", k), {15'd0, bus_a.in_ready}, 16'd0);
            check($sformatf("stall%0d word_a", k), bus_a.out_word, 16'h2211);
            check($sformatf("stall%0d word_b", k), bus_b.out_word, 16'h1122);
            check($sformatf("stall%0d count_a", k), {12'd0, cnt_a}, 16'd1);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
        #1;
        check("release in_ready_a", {15'd0, bus_a.in_ready}, 16'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        #1;
        check("tail out_valid_a", {15'd0, bus_a.out_valid}, 16'd1);
        check("tail word_a", bus_a.out_word, 16'h0033);
        check("tail word_b", bus_b.out_word, 16'h33A5);
        check("tail partial_a", {15'd0, bus_a.out_partial}, 16'd1);
        check("tail count_a", {12'd0, cnt_a}, 16'd2);
        @(negedge clk);
        #1;
        check("final out_valid_a", {15'd0, bus_a.out_valid}, 16'd0);
        check("final count_a", {12'd0, cnt_a}, 16'd3);
        check("final count_b", cnt_b, 16'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
